// File: rtl/bitserial_alu_ctrl_if.sv
// Request/response bus between the register/control layer and the bit-serial sequencer.
// Latency: none (wires only); the sequencer defines the timing of each signal.
// Backpressure: none; start is only honoured while the sequencer is idle, otherwise dropped.
//
// Signals:
//   start, op_a, op_b, opsel, cin_init  -- request, driven by the master
//   busy, done, result, cout_final      -- status/response, driven by the slave (sequencer)
interface bitserial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       opsel;
  logic             cin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_final;

  modport master (
    output start, op_a, op_b, opsel, cin_init,
    input  busy, done, result, cout_final
  );

  modport slave (
    input  start, op_a, op_b, opsel, cin_init,
    output busy, done, result, cout_final
  );
endinterface

// File: rtl/bitserial_alu_ctrl.sv
// Sequences an external combinational 1-bit slice through a WIDTH-bit operation, LSB first.
// Latency: start accepted at edge 0, WIDTH RUN cycles, done pulses in the cycle after edge WIDTH.
// Backpressure: start is accepted only in IDLE; requests while busy/done are dropped, not queued.
//
// Ports:
//   clk, rst            -- single clock, synchronous active-high reset
//   ctrl (slave)        -- start/op_a/op_b/opsel/cin_init in; busy/done/result/cout_final out
//   slc_op1/op2/cin/opsel out, slc_result/slc_cout in -- connection to the 1-bit slice
module bitserial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bitserial_alu_ctrl_if.slave  ctrl,
  output logic                 slc_op1,
  output logic                 slc_op2,
  output logic                 slc_cin,
  output logic [2:0]           slc_opsel,
  input  logic                 slc_result,
  input  logic                 slc_cout
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [2:0]       op_r_q, op_r_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_final_q, cout_final_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_sr_d     = res_sr_q;
    op_r_d       = op_r_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    cout_final_d = cout_final_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (ctrl.start) begin
          a_sr_d  = ctrl.op_a;
          b_sr_d  = ctrl.op_b;
          op_r_d  = ctrl.opsel;
          carry_d = ctrl.cin_init;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        res_sr_d = {slc_result, res_sr_q[WIDTH-1:1]};
        carry_d  = slc_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Last bit: publish the assembled word and this bit's carry-out together.
          result_d     = {slc_result, res_sr_q[WIDTH-1:1]};
          cout_final_d = slc_cout;
          cnt_d        = '0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_sr_q     <= '0;
      op_r_q       <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      cout_final_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_sr_q     <= res_sr_d;
      op_r_q       <= op_r_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      cout_final_q <= cout_final_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Slice sees live register bits only while running; otherwise it is held at all-zero.
  assign slc_op1   = busy_q & a_sr_q[0];
  assign slc_op2   = busy_q & b_sr_q[0];
  assign slc_cin   = busy_q & carry_q;
  assign slc_opsel = busy_q ? op_r_q : 3'b000;

  assign ctrl.busy       = busy_q;
  assign ctrl.done       = done_q;
  assign ctrl.result     = result_q;
  assign ctrl.cout_final = cout_final_q;

endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// Self-checking bench for bitserial_alu_ctrl with a behavioural 1-bit slice attached.
// Latency: expects done WIDTH+1 cycles after the accepting edge.
// Backpressure: issues a new request only once the sequencer reports idle.
module tb_bitserial_alu_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitserial_alu_ctrl_if #(.WIDTH(W)) ctrl ();

  logic       slc_op1, slc_op2, slc_cin, slc_result, slc_cout;
  logic [2:0] slc_opsel;

  bitserial_alu_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl),
    .slc_op1    (slc_op1),
    .slc_op2    (slc_op2),
    .slc_cin    (slc_cin),
    .slc_opsel  (slc_opsel),
    .slc_result (slc_result),
    .slc_cout   (slc_cout)
  );

  // Logic_block slice: 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 add,
  // 101 inverted add of inverted operands, 110 subtract (a + ~b + cin), 111 pass b.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  function automatic logic [1:0] slice_bit(input logic [2:0] op, input logic a, input logic b,
                                           input logic c);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~a};
      3'd4:    return {maj(a, b, c), a ^ b ^ c};
      3'd5:    return {maj(~a, ~b, c), ~(a ^ b ^ c)};
      3'd6:    return {maj(a, ~b, c), a ^ ~b ^ c};
      default: return {1'b0, b};
    endcase
  endfunction

  always_comb {slc_cout, slc_result} = slice_bit(slc_opsel, slc_op1, slc_op2, slc_cin);

  // Word-level reference: result, final carry, and the carry-in seen by each bit position.
  typedef struct packed {
    logic         cout;
    logic [W-1:0] res;
    logic [W-1:0] cins;
  } exp_t;

  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic cin);
    exp_t         r;
    logic [W:0]   s;
    logic [W-1:0] x, y;
    r      = '0;
    r.cins = W'(cin);
    x      = a;
    y      = b;
    case (op)
      3'd0: r.res = a & b;
      3'd1: r.res = a | b;
      3'd2: r.res = a ^ b;
      3'd3: r.res = ~a;
      3'd7: r.res = b;
      default: begin
        if (op == 3'd5) begin x = ~a; y = ~b; end
        if (op == 3'd6) y = ~b;
        s      = {1'b0, x} + {1'b0, y} + (W+1)'(cin);
        r.res  = (op == 3'd5) ? ~s[W-1:0] : s[W-1:0];
        r.cout = s[W];
        r.cins = s[W-1:0] ^ x ^ y;
      end
    endcase
    return r;
  endfunction

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ctrl.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", 32'(ctrl.result), 32'(mon_e.res));
        chk("cout_final", 32'(ctrl.cout_final), 32'(mon_e.cout));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((ctrl.busy || ctrl.done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("wait_idle");
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!ctrl.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout("wait_done");
  endtask

  // One request with a single-cycle start; operands are scrambled once accepted.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    exp_t         e;
    int           n = 0;
    int           nb = 0;
    bit           got_done = 0;
    logic [W-1:0] trace = '0;
    wait_idle();
    ctrl.start    = 1'b1;
    ctrl.op_a     = a;
    ctrl.op_b     = b;
    ctrl.opsel    = op;
    ctrl.cin_init = cin;
    e = ref_model(op, a, b, cin);
    exp_q.push_back(e);
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        ctrl.start    = 1'b0;
        ctrl.op_a     = W'($urandom);
        ctrl.op_b     = W'($urandom);
        ctrl.opsel    = 3'($urandom);
        ctrl.cin_init = 1'($urandom);
      end
      if (ctrl.busy) begin
        if (nb < W) trace[nb] = slc_cin;
        nb++;
      end
      if (ctrl.done) got_done = 1;
    end
    if (!got_done) timeout("run_op_done");
    else begin
      chk("latency", 32'(n), 32'(W + 1));
      chk("busy_cycles", 32'(nb), 32'(W));
      chk("carry_in_trace", 32'(trace), 32'(e.cins));
      chk("slc_zero_in_done", {27'd0, slc_op1, slc_op2, slc_cin, slc_opsel}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   dones;
    ctrl.start    = 1'b0;
    ctrl.op_a     = '0;
    ctrl.op_b     = '0;
    ctrl.opsel    = '0;
    ctrl.cin_init = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(ctrl.busy), 32'd0);
    chk("rst_done", 32'(ctrl.done), 32'd0);
    chk("rst_result", 32'(ctrl.result), 32'd0);
    chk("rst_cout", 32'(ctrl.cout_final), 32'd0);
    chk("rst_slc", {27'd0, slc_op1, slc_op2, slc_cin, slc_opsel}, 32'd0);
    rst = 1'b0;

    // T1..T3 directed
    run_op(3'b000, 8'hF0, 8'h3C, 1'b0);
    run_op(3'b010, 8'hA5, 8'hFF, 1'b0);
    run_op(3'b011, 8'h0F, 8'h00, 1'b0);
    run_op(3'b101, 8'h00, 8'h00, 1'b0);

    // T4: start held high with operand churn during RUN, then re-accept
    wait_idle();
    ctrl.start    = 1'b1;
    ctrl.op_a     = 8'h3C;
    ctrl.op_b     = 8'h0F;
    ctrl.opsel    = 3'b000;
    ctrl.cin_init = 1'b0;
    exp_q.push_back(ref_model(3'b000, 8'h3C, 8'h0F, 1'b0));
    begin
      int n = 0;
      @(negedge clk);
      while (!ctrl.done && n < 40) begin
        ctrl.op_a = W'($urandom);
        @(negedge clk);
        n++;
      end
      if (n >= 40) timeout("t4_done");
    end
    ctrl.op_a  = 8'h96;
    ctrl.op_b  = 8'h5A;
    ctrl.opsel = 3'b010;
    exp_q.push_back(ref_model(3'b010, 8'h96, 8'h5A, 1'b0));
    @(negedge clk);
    chk("t4_gap_busy", 32'(ctrl.busy), 32'd0);
    @(negedge clk);
    chk("t4_reaccept_busy", 32'(ctrl.busy), 32'd1);
    ctrl.start = 1'b0;
    wait_done();

    // T5: reset in the middle of RUN aborts with no done
    wait_idle();
    ctrl.start    = 1'b1;
    ctrl.op_a     = 8'h5F;
    ctrl.op_b     = 8'hA3;
    ctrl.opsel    = 3'b100;
    ctrl.cin_init = 1'b1;
    @(negedge clk);
    ctrl.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_before_rst", 32'(ctrl.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(ctrl.busy), 32'd0);
    chk("t5_result", 32'(ctrl.result), 32'd0);
    chk("t5_cout", 32'(ctrl.cout_final), 32'd0);
    dones = 0;
    repeat (14) begin
      @(negedge clk);
      if (ctrl.done) dones++;
    end
    chk("t5_no_done", 32'(dones), 32'd0);

    // T6: idle slice outputs and result hold after done
    e = ref_model(3'b110, 8'h47, 8'h19, 1'b1);
    run_op(3'b110, 8'h47, 8'h19, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_result_hold", 32'(ctrl.result), 32'(e.res));
      chk("t6_slc_idle", {27'd0, slc_op1, slc_op2, slc_cin, slc_opsel}, 32'd0);
    end

    // Random operations across all op codes
    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
